// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module   : id_ex_stage_pkg
// Purpose  : ALUOp encodings and control-bundle layout shared by decode,
//            the ID/EX boundary and execute.
// Revision : 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam logic [1:0] c_aluop_add    = 2'b00;  // loads/stores: address add
  localparam logic [1:0] c_aluop_branch = 2'b01;  // branch compare
  localparam logic [1:0] c_aluop_funct  = 2'b10;  // R/I-type, funct3/funct7 select

  localparam logic [4:0] c_reg_x0 = 5'd0;

  // Control bundle, MSB first. Execute unpacks fields by name.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t c_ctrl_nop = '0;

  // A slot that is not a real instruction must never carry side-effecting control.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic keep);
    return keep ? c : c_ctrl_nop;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module   : load_use_detect
// Purpose  : Flags an ID instruction that reads the destination of a load in EX.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  logic w_rs1_dep;
  logic w_rs2_dep;

  assign w_rs1_dep = id_use_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_dep = id_use_rs2 & (id_rs2 == ex_rd);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard = ex_valid & ex_mem_read & (ex_rd != c_reg_x0) & id_valid
                & (w_rs1_dep | w_rs2_dep);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use bubble insertion, downstream
//            hold, branch flush and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int width = 32,
  parameter int cntw  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [width-1:0] id_pc,
  input  logic [width-1:0] id_rd1,
  input  logic [width-1:0] id_rd2,
  input  logic [width-1:0] id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7,
  input  logic [1:0]       id_ALUOp,
  input  logic             id_ALUSrc,
  input  logic             id_Branch,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             stall_in,
  input  logic             flush,
  output logic             ex_valid,
  output logic [width-1:0] ex_pc,
  output logic [width-1:0] ex_rd1,
  output logic [width-1:0] ex_rd2,
  output logic [width-1:0] ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_use_rs1,
  output logic             ex_use_rs2,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_ALUSrc,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic             stall_id,
  output logic [cntw-1:0]  bubble_cnt
);

  localparam int c_data_w = 4 * width + 21;

  logic                r_valid;
  ctrl_t               r_ctrl;
  logic [c_data_w-1:0] r_data;
  logic [cntw-1:0]     r_bubble_cnt;

  ctrl_t               w_id_ctrl;
  logic [c_data_w-1:0] w_id_data;
  logic                w_hazard;
  logic                w_bubble;

  assign w_id_ctrl = '{alu_op:     id_ALUOp,
                       alu_src:    id_ALUSrc,
                       branch:     id_Branch,
                       mem_read:   id_MemRead,
                       mem_write:  id_MemWrite,
                       reg_write:  id_RegWrite,
                       mem_to_reg: id_MemtoReg};

  assign w_id_data = {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
                      id_use_rs1, id_use_rs2, id_funct3, id_funct7};

  load_use_detect u_load_use_detect (
    .ex_valid    (r_valid),
    .ex_mem_read (r_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .hazard      (w_hazard)
  );

  // Flush outranks both holds; a held hazard is not counted until it is acted on.
  assign stall_id = (w_hazard | stall_in) & ~flush;
  assign w_bubble = w_hazard & ~stall_in & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= c_ctrl_nop;
      r_data  <= '0;
    end else if (flush || w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= c_ctrl_nop;
      r_data  <= '0;
    end else if (!stall_in) begin
      r_valid <= id_valid;
      r_ctrl  <= gate_ctrl(w_id_ctrl, id_valid);
      r_data  <= w_id_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid = r_valid;
  assign {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
          ex_use_rs1, ex_use_rs2, ex_funct3, ex_funct7} = r_data;

  assign ex_ALUOp    = r_ctrl.alu_op;
  assign ex_ALUSrc   = r_ctrl.alu_src;
  assign ex_Branch   = r_ctrl.branch;
  assign ex_MemRead  = r_ctrl.mem_read;
  assign ex_MemWrite = r_ctrl.mem_write;
  assign ex_RegWrite = r_ctrl.reg_write;
  assign ex_MemtoReg = r_ctrl.mem_to_reg;

  assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed and random checks of id_ex_stage against a cycle model;
//            a second copy with a 4-bit counter exercises saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int W  = 32;
  localparam int DW = 4 * W + 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, id_valid, id_use_rs1, id_use_rs2, id_funct7;
  logic [W-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic [2:0]   id_funct3;
  logic [1:0]   id_ALUOp;
  logic         id_ALUSrc, id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg;
  logic         stall_in, flush;

  logic         ex_valid, ex_use_rs1, ex_use_rs2, ex_funct7;
  logic [W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]   ex_rs1, ex_rs2, ex_rd;
  logic [2:0]   ex_funct3;
  logic [1:0]   ex_ALUOp;
  logic         ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg;
  logic         stall_id;
  logic [15:0]  bubble_cnt;

  logic         s_valid, s_use_rs1, s_use_rs2, s_funct7;
  logic [W-1:0] s_pc, s_rd1, s_rd2, s_imm;
  logic [4:0]   s_rs1, s_rs2, s_rd;
  logic [2:0]   s_funct3;
  logic [1:0]   s_ALUOp;
  logic         s_ALUSrc, s_Branch, s_MemRead, s_MemWrite, s_RegWrite, s_MemtoReg;
  logic         s_stall_id;
  logic [3:0]   s_bubble_cnt;

  id_ex_stage #(.width(W), .cntw(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .stall_in(stall_in),
    .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc),
    .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .stall_id(stall_id),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.width(W), .cntw(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .stall_in(stall_in),
    .flush(flush), .ex_valid(s_valid), .ex_pc(s_pc), .ex_rd1(s_rd1),
    .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_use_rs1(s_use_rs1), .ex_use_rs2(s_use_rs2), .ex_funct3(s_funct3),
    .ex_funct7(s_funct7), .ex_ALUOp(s_ALUOp), .ex_ALUSrc(s_ALUSrc),
    .ex_Branch(s_Branch), .ex_MemRead(s_MemRead), .ex_MemWrite(s_MemWrite),
    .ex_RegWrite(s_RegWrite), .ex_MemtoReg(s_MemtoReg), .stall_id(s_stall_id),
    .bubble_cnt(s_bubble_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Model of the EX slot: what should be sitting there after each edge.
  bit          m_init = 1'b0;
  bit          m_valid;
  logic [7:0]  m_ctrl;
  logic [DW-1:0] m_data;
  logic [4:0]  m_rd;
  bit          m_memread;
  bit          m_dchk;
  int          m_bubbles;

  function automatic logic [7:0] in_ctrl();
    return {id_ALUOp, id_ALUSrc, id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg};
  endfunction

  function automatic logic [DW-1:0] in_data();
    return {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
            id_use_rs1, id_use_rs2, id_funct3, id_funct7};
  endfunction

  function automatic bit model_hazard();
    bit dep;
    dep = (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
    return m_valid && m_memread && (m_rd != 5'd0) && id_valid && dep;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slot();
    m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_rd = '0; m_memread = 1'b0; m_dchk = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven; returns on the next falling edge.
  task automatic cycle();
    bit hz;
    int e16, e4;
    #1;
    hz = model_hazard();
    if (m_init) begin
      chk("stall_id", {255'd0, stall_id}, {255'd0, (hz | stall_in) & ~flush});
      chk("stall_id_c4", {255'd0, s_stall_id}, {255'd0, (hz | stall_in) & ~flush});
    end
    @(posedge clk);
    if (rst) begin
      clear_slot(); m_bubbles = 0; m_init = 1'b1;
    end else if (flush) begin
      clear_slot();
    end else if (stall_in) begin
      // slot frozen
    end else if (hz) begin
      m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_memread = 1'b0; m_dchk = 1'b0;
      m_bubbles++;
    end else begin
      m_valid = id_valid; m_ctrl = id_valid ? in_ctrl() : 8'd0; m_data = in_data();
      m_rd = id_rd; m_memread = id_valid && id_MemRead; m_dchk = 1'b1;
    end
    #1;
    if (m_init) begin
      e16 = (m_bubbles > 65535) ? 65535 : m_bubbles;
      e4  = (m_bubbles > 15) ? 15 : m_bubbles;
      chk("ex_valid", {255'd0, ex_valid}, {255'd0, m_valid});
      chk("ex_ctrl", {248'd0, ex_ALUOp, ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite,
                      ex_RegWrite, ex_MemtoReg}, {248'd0, m_ctrl});
      if (m_dchk)
        chk("ex_data", {107'd0, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                        ex_use_rs1, ex_use_rs2, ex_funct3, ex_funct7}, {107'd0, m_data});
      chk("ex_valid_c4", {255'd0, s_valid}, {255'd0, m_valid});
      chk("bubble_cnt", {240'd0, bubble_cnt}, e16);
      chk("bubble_cnt_c4", {252'd0, s_bubble_cnt}, e4);
    end
    @(negedge clk);
  endtask

  task automatic rand_id();
    id_valid    = ($urandom_range(0, 4) != 0);
    id_pc       = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_rd       = 5'($urandom_range(0, 3));
    id_use_rs1  = 1'($urandom); id_use_rs2 = 1'($urandom);
    id_funct3   = 3'($urandom); id_funct7 = 1'($urandom);
    id_ALUOp    = 2'($urandom); id_ALUSrc = 1'($urandom); id_Branch = 1'($urandom);
    id_MemRead  = ($urandom_range(0, 4) < 2); id_MemWrite = 1'($urandom);
    id_RegWrite = 1'($urandom); id_MemtoReg = 1'($urandom);
  endtask

  task automatic set_instr(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                           input bit u2, input logic [4:0] rd, input logic [1:0] aluop,
                           input bit memread);
    id_valid = 1'b1; id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd;
    id_funct3 = memread ? 3'b010 : 3'b000; id_funct7 = 1'b0;
    id_ALUOp = aluop; id_ALUSrc = memread; id_Branch = 1'b0; id_MemRead = memread;
    id_MemWrite = 1'b0; id_RegWrite = 1'b1; id_MemtoReg = memread;
  endtask

  initial begin
    // Reset with random decode contents
    rand_id();
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    cycle();
    rst = 1'b0;

    // Pass-through
    set_instr(5'd1, 1'b1, 5'd2, 1'b0, 5'd3, 2'b10, 1'b0);
    id_pc = 32'h100; id_rd1 = 32'd5; id_imm = 32'hFFFF_FFF0; id_ALUSrc = 1'b1;
    cycle();

    // Load-use: lw x5, then add x6,x5,x1 held for one bubble, then enters
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 2'b00, 1'b1);
    cycle();
    set_instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 2'b10, 1'b0);
    cycle();
    cycle();
    cycle();

    // Load targeting x0 never stalls
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 2'b00, 1'b1);
    cycle();
    set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 2'b10, 1'b0);
    cycle();

    // Flush beats a pending hazard
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 2'b00, 1'b1);
    cycle();
    set_instr(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 2'b10, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Downstream hold with changing decode contents, then release
    set_instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 2'b10, 1'b0);
    cycle();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle();
    end
    stall_in = 1'b0;
    rand_id();
    cycle();

    // Enough load-use pairs to saturate the narrow counter
    for (int i = 0; i < 20; i++) begin
      set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 2'b00, 1'b1);
      cycle();
      set_instr(5'd1, 1'b1, 5'd3, 1'b0, 5'd4, 2'b10, 1'b0);
      cycle();
      cycle();
    end

    // Reset while a hold is in progress
    set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 2'b00, 1'b1);
    cycle();
    set_instr(5'd1, 1'b1, 5'd3, 1'b0, 5'd4, 2'b10, 1'b0);
    stall_in = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; stall_in = 1'b0;
    cycle();

    // Random traffic with small register indices so hazards are frequent
    for (int i = 0; i < 500; i++) begin
      rand_id();
      rst      = ($urandom_range(0, 59) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 6) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
